// File: rtl/prco_fetch_unit_pkg.sv
// Shared constants for the prco fetch front end: default widths, reset PC and
// the encodings of the single-bit inflight and drop state flags.
package prco_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  // Inflight: a read was accepted on the previous edge, its data is on the bus now.
  localparam logic INFLIGHT_NONE    = 1'b0;
  localparam logic INFLIGHT_PENDING = 1'b1;

  // Drop: the response of the current in-flight read belongs to a flushed stream.
  localparam logic DROP_KEEP    = 1'b0;
  localparam logic DROP_DISCARD = 1'b1;

endpackage

// File: rtl/prco_fetch_fifo.sv
// Prefetch queue: DEPTH-entry register FIFO with first-word fall-through.
// Flush has priority over push and pop; the head reads as zero when empty.
module prco_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rdata,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Qualified push/pop and next pointer/count state.
  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (cnt_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are don't-care while not counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Head and status outputs.
  always_comb begin
    valid = (cnt_q != '0);
    full  = (cnt_q == CntW'(DEPTH));
    count = cnt_q;
    rdata = valid ? mem[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/prco_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues reads to the shared
// memory port, buffers returned words with their addresses and redirects on branch.
module prco_fetch_unit
  import prco_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_en,
  output logic                       q_mem_req,
  output logic [ADDR_W-1:0]          q_mem_addr,
  input  logic                       i_mem_gnt,
  input  logic [INSTR_W-1:0]         i_mem_data,
  output logic                       q_valid,
  output logic [INSTR_W-1:0]         q_instr,
  output logic [ADDR_W-1:0]          q_pc,
  input  logic                       i_ready,
  input  logic                       i_branch,
  input  logic [ADDR_W-1:0]          i_branch_target,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       q_full
);

  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned EntW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pending_pc_q;
  logic              inflight_q, inflight_d;
  logic              drop_q, drop_d;
  logic              accept, push, pop;
  logic [SumW-1:0]   occupancy;
  logic [EntW-1:0]   head;

  // Request and handshake decode. The space check counts the in-flight read
  // but not a same-cycle pop, so a push can never land in a full queue.
  always_comb begin
    occupancy  = SumW'(q_count) + SumW'(inflight_q);
    q_mem_req  = i_reset_n & i_en & ~i_branch & (occupancy < SumW'(DEPTH));
    q_mem_addr = fetch_pc_q;
    accept     = q_mem_req & i_mem_gnt;
    push       = (inflight_q == INFLIGHT_PENDING) & (drop_q == DROP_KEEP);
    pop        = q_valid & i_ready;
  end

  // Next fetch PC, inflight and drop; a branch overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (i_branch)    fetch_pc_d = i_branch_target;
    else if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    inflight_d = accept ? INFLIGHT_PENDING : INFLIGHT_NONE;
    drop_d     = (i_branch & accept) ? DROP_DISCARD : DROP_KEEP;
  end

  // PC, request tracking and pending-address registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_pc_q   <= ADDR_W'(RESET_PC);
      pending_pc_q <= '0;
      inflight_q   <= INFLIGHT_NONE;
      drop_q       <= DROP_KEEP;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (accept) pending_pc_q <= fetch_pc_q;
    end
  end

  prco_fetch_fifo #(
    .WIDTH (EntW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (push),
    .pop   (pop),
    .flush (i_branch),
    .wdata ({pending_pc_q, i_mem_data}),
    .rdata (head),
    .valid (q_valid),
    .count (q_count),
    .full  (q_full)
  );

  // Split the queue head into address and instruction.
  always_comb begin
    q_pc    = head[EntW-1:INSTR_W];
    q_instr = head[INSTR_W-1:0];
  end

endmodule

// File: tb/tb_prco_fetch_unit.sv
// Bench for prco_fetch_unit: directed scenarios plus random traffic, checked
// against a queue-level model of the fetch stream.
module tb_prco_fetch_unit;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned RESET_PC = 16'h0010;
  localparam int unsigned CNT_W    = $clog2(DEPTH+1);

  logic               i_clk;
  logic               i_reset_n;
  logic               i_en;
  logic               q_mem_req;
  logic [ADDR_W-1:0]  q_mem_addr;
  logic               i_mem_gnt;
  logic [INSTR_W-1:0] i_mem_data;
  logic               q_valid;
  logic [INSTR_W-1:0] q_instr;
  logic [ADDR_W-1:0]  q_pc;
  logic               i_ready;
  logic               i_branch;
  logic [ADDR_W-1:0]  i_branch_target;
  logic [CNT_W-1:0]   q_count;
  logic               q_full;

  prco_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_en            (i_en),
    .q_mem_req       (q_mem_req),
    .q_mem_addr      (q_mem_addr),
    .i_mem_gnt       (i_mem_gnt),
    .i_mem_data      (i_mem_data),
    .q_valid         (q_valid),
    .q_instr         (q_instr),
    .q_pc            (q_pc),
    .i_ready         (i_ready),
    .i_branch        (i_branch),
    .i_branch_target (i_branch_target),
    .q_count         (q_count),
    .q_full          (q_full)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: addresses already returned and queued, next fetch address,
  // and whether a read is outstanding.
  logic [ADDR_W-1:0] m_q[$];
  logic [ADDR_W-1:0] m_pc;
  logic [ADDR_W-1:0] m_pend;
  bit                m_infl;
  bit                m_drop;

  // Memory stub state: what was accepted on the last edge.
  bit                mem_acc;
  logic [ADDR_W-1:0] mem_addr;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return INSTR_W'(a) + INSTR_W'(16'h1000);
  endfunction

  task automatic step(input bit en, input bit gnt, input bit rdy, input bit br,
                      input logic [ADDR_W-1:0] tgt);
    bit exp_req, exp_valid, acc, pop;
    @(negedge i_clk);
    i_en = en; i_mem_gnt = gnt; i_ready = rdy; i_branch = br; i_branch_target = tgt;
    #1;
    exp_req   = en && !br && ((m_q.size() + int'(m_infl)) < DEPTH);
    exp_valid = (m_q.size() != 0);
    check_eq("mem_req", q_mem_req, exp_req);
    check_eq("mem_addr", q_mem_addr, m_pc);
    check_eq("valid", q_valid, exp_valid);
    check_eq("count", q_count, m_q.size());
    check_eq("full", q_full, m_q.size() == DEPTH);
    check_eq("no_overflow", q_count <= DEPTH, 1);
    if (exp_valid) begin
      check_eq("head_pc", q_pc, m_q[0]);
      check_eq("head_instr", q_instr, mem_word(m_q[0]));
    end
    mem_acc  = q_mem_req & i_mem_gnt;
    mem_addr = q_mem_addr;
    acc = exp_req && gnt;
    pop = exp_valid && rdy;
    if (br) begin
      m_q.delete();
      m_drop = acc;
      m_pc   = tgt;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl && !m_drop) m_q.push_back(m_pend);
      m_drop = 0;
      if (acc) begin
        m_pend = m_pc;
        m_pc   = m_pc + ADDR_W'(1);
      end
    end
    m_infl = acc;
    @(posedge i_clk);
    #1;
    i_mem_data = mem_acc ? mem_word(mem_addr) : INSTR_W'($urandom);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_eq("rst_valid", q_valid, 0);
    check_eq("rst_count", q_count, 0);
    check_eq("rst_full", q_full, 0);
    check_eq("rst_instr", q_instr, 0);
    check_eq("rst_pc", q_pc, 0);
    check_eq("rst_req", q_mem_req, 0);
    check_eq("rst_addr", q_mem_addr, RESET_PC);
    m_q.delete();
    m_pc   = ADDR_W'(RESET_PC);
    m_infl = 0;
    m_drop = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n = 1'b1; i_en = 1'b0; i_mem_gnt = 1'b0; i_mem_data = '0;
    i_ready = 1'b0; i_branch = 1'b0; i_branch_target = '0;
    m_pc = ADDR_W'(RESET_PC); m_pend = '0; m_infl = 0; m_drop = 0;
    mem_acc = 0; mem_addr = '0;

    // Streaming from reset at one instruction per cycle.
    do_reset();
    repeat (12) step(1, 1, 1, 0, '0);

    // Backpressure: queue fills, requests stop, then drains in order.
    do_reset();
    repeat (8) step(1, 1, 0, 0, '0);
    check_eq("bp_full", q_full, 1);
    check_eq("bp_addr", q_mem_addr, 16'h0014);
    repeat (10) step(1, 1, 1, 0, '0);

    // Arbitration gaps.
    for (int i = 0; i < 12; i++) step(1, (i % 2) == 0, 1, 0, '0);

    // Branch flush with three entries queued and one read in flight.
    do_reset();
    repeat (4) step(1, 1, 0, 0, '0);
    check_eq("flush_setup_count", q_count, 3);
    step(1, 1, 1, 1, 16'h0200);
    check_eq("flush_valid", q_valid, 0);
    check_eq("flush_addr", q_mem_addr, 16'h0200);
    repeat (6) step(1, 1, 1, 0, '0);

    // Address wrap.
    step(1, 1, 1, 1, 16'hFFFE);
    repeat (8) step(1, 1, 1, 0, '0);

    // Enable dropped with a read in flight.
    step(1, 1, 0, 0, '0);
    repeat (6) step(0, 1, 1, 0, '0);
    step(1, 1, 1, 0, '0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [ADDR_W-1:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? ADDR_W'(16'hFFFC + $urandom_range(0, 3))
                                        : ADDR_W'($urandom);
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt);
    end

    // Asynchronous reset mid-burst, then restart.
    do_reset();
    repeat (3) step(1, 1, 0, 0, '0);
    do_reset();
    repeat (8) step(1, 1, 1, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
